// File: rtl/billiard_collision_pkg.sv
// Shared types and width helpers for the billiard multi-ball collision resolver.
// Widths follow the full-precision chain d -> dot -> dot*d used by the resolver datapath.
package billiard_collision_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DIV_X,
        ST_DIV_Y,
        ST_APPLY,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } ball_vel_t;

    // Width of |dot*d|: d is COORD_W+1, dv is VEL_W+1, dot adds one carry bit.
    function automatic int num_w(input int coord_w, input int vel_w);
        int d_w;
        int dot_w;
        d_w   = coord_w + 1;
        dot_w = d_w + (vel_w + 1) + 1;
        return dot_w + d_w - 1;
    endfunction

    function automatic int ball_diam_sq(input int diam);
        return diam * diam;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so a divide occupies DIVIDEND_W cycles up to done.
module seq_udiv #(
    parameter int DIVIDEND_W = 36,
    parameter int DIVISOR_W  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVISOR_W-1:0]  dsr_r;
    logic [DIVIDEND_W-1:0] acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  done_r;

    logic [DIVISOR_W-1:0]  src_rem;
    logic [DIVISOR_W-1:0]  src_dsr;
    logic [DIVIDEND_W-1:0] src_acc;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] acc_nxt;

    // acc_r shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        src_rem = busy_r ? rem_r : '0;
        src_dsr = busy_r ? dsr_r : divisor;
        src_acc = busy_r ? acc_r : dividend;
        trial   = {src_rem, src_acc[DIVIDEND_W-1]};
        diff    = trial - {1'b0, src_dsr};
        fits    = trial >= {1'b0, src_dsr};
        rem_nxt = fits ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
        acc_nxt = {src_acc[DIVIDEND_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r  <= '0;
            dsr_r  <= '0;
            acc_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !busy_r) begin
                rem_r  <= rem_nxt;
                acc_r  <= acc_nxt;
                dsr_r  <= divisor;
                cnt_r  <= CNT_W'(DIVIDEND_W - 1);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                rem_r <= rem_nxt;
                acc_r <= acc_nxt;
                cnt_r <= cnt_r - 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = acc_r;

endmodule

// File: rtl/ball_collision_resolver.sv
// Walks every ball pair (i<j) in fixed order and exchanges the centre-line velocity
// component of touching, approaching pairs; results are published with a done pulse.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | snapshot inputs, pair (0,1), clear mask
// ST_CHECK | contact/approach test for pair (i,j)
// ST_DIV_X | qx = dot*dx/dist2 on the shared divider
// ST_DIV_Y | qy = dot*dy/dist2 on the shared divider
// ST_APPLY | v_i -= q, v_j += q with saturation
// ST_NEXT  | advance pair indices
// ST_DONE  | outputs valid, done pulse
module ball_collision_resolver
    import billiard_collision_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int COORD_W   = 11,
    parameter int VEL_W     = 11,
    parameter int BALL_DIAM = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_BALLS*COORD_W-1:0] pos_x_in,
    input  logic [NUM_BALLS*COORD_W-1:0] pos_y_in,
    input  logic [NUM_BALLS*VEL_W-1:0]   vel_x_in,
    input  logic [NUM_BALLS*VEL_W-1:0]   vel_y_in,
    output logic [NUM_BALLS*VEL_W-1:0]   vel_x_out,
    output logic [NUM_BALLS*VEL_W-1:0]   vel_y_out,
    output logic [NUM_BALLS-1:0]         collision_mask,
    output logic                         busy,
    output logic                         done
);

    localparam int D_W    = COORD_W + 1;
    localparam int DV_W   = VEL_W + 1;
    localparam int MUL_W  = D_W + DV_W;
    localparam int SQ_W   = 2 * D_W;
    localparam int DOT_W  = MUL_W + 1;
    localparam int PROD_W = DOT_W + D_W;
    localparam int NUM_W  = num_w(COORD_W, VEL_W);
    localparam int Q_W    = NUM_W + 1;
    localparam int SUM_W  = Q_W + 1;
    localparam int IDX_W  = $clog2(NUM_BALLS);

    localparam logic [SQ_W-1:0]         DIAM_SQ = SQ_W'(ball_diam_sq(BALL_DIAM));
    localparam logic signed [SUM_W-1:0] VEL_MAX = SUM_W'((1 << (VEL_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] VEL_MIN = SUM_W'(-(1 << (VEL_W - 1)));
    localparam logic [IDX_W-1:0]        LAST_I  = IDX_W'(NUM_BALLS - 2);
    localparam logic [IDX_W-1:0]        LAST_J  = IDX_W'(NUM_BALLS - 1);

    state_t state, state_nxt;

    logic signed [COORD_W-1:0] px_r [NUM_BALLS];
    logic signed [COORD_W-1:0] py_r [NUM_BALLS];
    logic signed [VEL_W-1:0]   vx_r [NUM_BALLS];
    logic signed [VEL_W-1:0]   vy_r [NUM_BALLS];
    logic [NUM_BALLS-1:0]      mask_r;
    logic [IDX_W-1:0]          idx_i;
    logic [IDX_W-1:0]          idx_j;
    logic signed [Q_W-1:0]     qx_r;
    logic signed [Q_W-1:0]     qy_r;

    logic signed [D_W-1:0]    dx, dy;
    logic signed [DV_W-1:0]   dvx, dvy;
    logic signed [MUL_W-1:0]  pxv, pyv;
    logic signed [SQ_W-1:0]   sqx, sqy;
    logic [SQ_W-1:0]          dist2;
    logic signed [DOT_W-1:0]  dot;
    logic signed [PROD_W-1:0] prod_x, prod_y, nprod_x, nprod_y;
    logic [NUM_W-1:0]         mag_x, mag_y;
    logic                     neg_x, neg_y;
    logic                     collide;
    logic                     last_pair;

    logic                     div_start, div_busy, div_done;
    logic [NUM_W-1:0]         div_dividend;
    logic [NUM_W-1:0]         div_quot;
    logic signed [Q_W-1:0]    q_pos;
    logic signed [SUM_W-1:0]  sum_vix, sum_viy, sum_vjx, sum_vjy;

    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [SUM_W-1:0] v);
        if (v > VEL_MAX) return VEL_MAX[VEL_W-1:0];
        if (v < VEL_MIN) return VEL_MIN[VEL_W-1:0];
        return v[VEL_W-1:0];
    endfunction

    // Pair geometry at full precision; all terms are held stable while the divider runs.
    assign dx      = D_W'(px_r[idx_j]) - D_W'(px_r[idx_i]);
    assign dy      = D_W'(py_r[idx_j]) - D_W'(py_r[idx_i]);
    assign dvx     = DV_W'(vx_r[idx_i]) - DV_W'(vx_r[idx_j]);
    assign dvy     = DV_W'(vy_r[idx_i]) - DV_W'(vy_r[idx_j]);
    assign pxv     = MUL_W'(dx) * MUL_W'(dvx);
    assign pyv     = MUL_W'(dy) * MUL_W'(dvy);
    assign sqx     = SQ_W'(dx) * SQ_W'(dx);
    assign sqy     = SQ_W'(dy) * SQ_W'(dy);
    assign dist2   = $unsigned(sqx) + $unsigned(sqy);
    assign dot     = DOT_W'(pxv) + DOT_W'(pyv);
    assign collide = (dist2 != '0) && (dist2 < DIAM_SQ) && !dot[DOT_W-1] && (dot != '0);

    assign prod_x  = PROD_W'(dot) * PROD_W'(dx);
    assign prod_y  = PROD_W'(dot) * PROD_W'(dy);
    assign nprod_x = -prod_x;
    assign nprod_y = -prod_y;
    assign mag_x   = prod_x[PROD_W-1] ? nprod_x[NUM_W-1:0] : prod_x[NUM_W-1:0];
    assign mag_y   = prod_y[PROD_W-1] ? nprod_y[NUM_W-1:0] : prod_y[NUM_W-1:0];
    assign neg_x   = dot[DOT_W-1] ^ dx[D_W-1];
    assign neg_y   = dot[DOT_W-1] ^ dy[D_W-1];
    assign q_pos   = $signed({1'b0, div_quot});

    assign last_pair = (idx_i == LAST_I) && (idx_j == LAST_J);

    assign sum_vix = SUM_W'(vx_r[idx_i]) - SUM_W'(qx_r);
    assign sum_viy = SUM_W'(vy_r[idx_i]) - SUM_W'(qy_r);
    assign sum_vjx = SUM_W'(vx_r[idx_j]) + SUM_W'(qx_r);
    assign sum_vjy = SUM_W'(vy_r[idx_j]) + SUM_W'(qy_r);

    seq_udiv #(
        .DIVIDEND_W (NUM_W),
        .DIVISOR_W  (SQ_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (dist2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = collide ? ST_DIV_X : ST_NEXT;
            ST_DIV_X: if (div_done) state_nxt = ST_DIV_Y;
            ST_DIV_Y: if (div_done) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_NEXT;
            ST_NEXT:  state_nxt = last_pair ? ST_DONE : ST_CHECK;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The Y divide is launched in the cycle the X quotient lands, keeping each axis at NUM_W cycles.
    always_comb begin
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        div_start    = !div_busy && (((state == ST_CHECK) && collide) ||
                                     ((state == ST_DIV_X) && div_done));
        div_dividend = (state == ST_DIV_X) ? mag_y : mag_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
                px_r[k] <= '0;
                py_r[k] <= '0;
                vx_r[k] <= '0;
                vy_r[k] <= '0;
            end
            mask_r <= '0;
            idx_i  <= '0;
            idx_j  <= '0;
            qx_r   <= '0;
            qy_r   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    for (int k = 0; k < NUM_BALLS; k++) begin
                        px_r[k] <= pos_x_in[k*COORD_W +: COORD_W];
                        py_r[k] <= pos_y_in[k*COORD_W +: COORD_W];
                        vx_r[k] <= vel_x_in[k*VEL_W +: VEL_W];
                        vy_r[k] <= vel_y_in[k*VEL_W +: VEL_W];
                    end
                    mask_r <= '0;
                    idx_i  <= '0;
                    idx_j  <= IDX_W'(1);
                end
                ST_DIV_X: if (div_done) qx_r <= neg_x ? -q_pos : q_pos;
                ST_DIV_Y: if (div_done) qy_r <= neg_y ? -q_pos : q_pos;
                ST_APPLY: begin
                    vx_r[idx_i]   <= sat_vel(sum_vix);
                    vy_r[idx_i]   <= sat_vel(sum_viy);
                    vx_r[idx_j]   <= sat_vel(sum_vjx);
                    vy_r[idx_j]   <= sat_vel(sum_vjy);
                    mask_r[idx_i] <= 1'b1;
                    mask_r[idx_j] <= 1'b1;
                end
                ST_NEXT: begin
                    if (idx_j == LAST_J) begin
                        idx_i <= idx_i + 1'b1;
                        idx_j <= idx_i + IDX_W'(2);
                    end else begin
                        idx_j <= idx_j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are loaded on the way into DONE so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            vel_x_out      <= '0;
            vel_y_out      <= '0;
            collision_mask <= '0;
        end else if ((state == ST_NEXT) && last_pair) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
                vel_x_out[k*VEL_W +: VEL_W] <= vx_r[k];
                vel_y_out[k*VEL_W +: VEL_W] <= vy_r[k];
            end
            collision_mask <= mask_r;
        end
    end

endmodule

// File: tb/tb_ball_collision_resolver.sv
// Bench for ball_collision_resolver: directed vector table, control sequences and
// randomized passes against an integer-arithmetic pair-walk model.
module tb_ball_collision_resolver;
    import billiard_collision_pkg::*;

    localparam int NB    = 4;
    localparam int CW    = 11;
    localparam int VW    = 11;
    localparam int DIAM  = 32;
    localparam int NUMW  = 36;
    localparam int NPAIR = NB * (NB - 1) / 2;
    localparam int NVEC  = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NB*CW-1:0]  pos_x_in, pos_y_in;
    logic [NB*VW-1:0]  vel_x_in, vel_y_in;
    logic [NB*VW-1:0]  vel_x_out, vel_y_out;
    logic [NB-1:0]     collision_mask;
    logic              busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ball_collision_resolver #(
        .NUM_BALLS (NB),
        .COORD_W   (CW),
        .VEL_W     (VW),
        .BALL_DIAM (DIAM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pos_x_in       (pos_x_in),
        .pos_y_in       (pos_y_in),
        .vel_x_in       (vel_x_in),
        .vel_y_in       (vel_y_in),
        .vel_x_out      (vel_x_out),
        .vel_y_out      (vel_y_out),
        .collision_mask (collision_mask),
        .busy           (busy),
        .done           (done)
    );

    typedef struct packed {
        logic [NB*CW-1:0] px;
        logic [NB*CW-1:0] py;
        logic [NB*VW-1:0] vx;
        logic [NB*VW-1:0] vy;
        logic [NB*VW-1:0] evx;
        logic [NB*VW-1:0] evy;
        logic [NB-1:0]    emask;
        logic [3:0]       ncoll;
    } vec_t;

    vec_t vt [NVEC];

    int               lat;
    int               ndone;
    logic [NB*VW-1:0] snap_vx, snap_vy;
    logic [NB-1:0]    snap_m;

    int        mpx [NB];
    int        mpy [NB];
    ball_vel_t mv  [NB];
    int        m_mask;
    int        m_coll;

    function automatic logic [NB*CW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[CW-1:0], c[CW-1:0], b[CW-1:0], a[CW-1:0]};
    endfunction

    function automatic int exp_lat(input int ncoll);
        return 2 + 2 * NPAIR + ncoll * (2 * NUMW + 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > 1023) return 1023;
        if (v < -1024) return -1024;
        return v;
    endfunction

    // Reference: sequential pair walk using plain signed arithmetic and C-style division.
    task automatic ref_model();
        m_mask = 0;
        m_coll = 0;
        for (int k = 0; k < NB; k++) begin
            mpx[k]  = int'($signed(pos_x_in[k*CW +: CW]));
            mpy[k]  = int'($signed(pos_y_in[k*CW +: CW]));
            mv[k].x = int'($signed(vel_x_in[k*VW +: VW]));
            mv[k].y = int'($signed(vel_y_in[k*VW +: VW]));
        end
        for (int i = 0; i < NB - 1; i++) begin
            for (int j = i + 1; j < NB; j++) begin
                longint dx, dy, dvx, dvy, d2, dt, qx, qy;
                dx  = mpx[j] - mpx[i];
                dy  = mpy[j] - mpy[i];
                dvx = longint'(mv[i].x) - longint'(mv[j].x);
                dvy = longint'(mv[i].y) - longint'(mv[j].y);
                d2  = dx * dx + dy * dy;
                dt  = dx * dvx + dy * dvy;
                if (d2 != 0 && d2 < DIAM * DIAM && dt > 0) begin
                    qx = (dt * dx) / d2;
                    qy = (dt * dy) / d2;
                    mv[i].x = clampv(longint'(mv[i].x) - qx);
                    mv[i].y = clampv(longint'(mv[i].y) - qy);
                    mv[j].x = clampv(longint'(mv[j].x) + qx);
                    mv[j].y = clampv(longint'(mv[j].y) + qy);
                    m_mask  = m_mask | (1 << i) | (1 << j);
                    m_coll++;
                end
            end
        end
    endtask

    // Called at a negedge with inputs already set; returns with outputs snapped at done.
    task automatic run_pass(input bit scramble);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (scramble && cyc == 2) begin
                pos_x_in = {$urandom, $urandom};
                pos_y_in = {$urandom, $urandom};
                vel_x_in = {$urandom, $urandom};
                vel_y_in = {$urandom, $urandom};
            end
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        lat     = cyc;
        snap_vx = vel_x_out;
        snap_vy = vel_y_out;
        snap_m  = collision_mask;
        ndone   = done ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    task automatic apply_vec(input int t);
        pos_x_in = vt[t].px;
        pos_y_in = vt[t].py;
        vel_x_in = vt[t].vx;
        vel_y_in = vt[t].vy;
    endtask

    initial begin
        int cyc;
        logic [NB*VW-1:0] evx, evy;

        vt[0] = '{px: pk(0, 20, 400, -400), py: pk(0, 0, 400, -400),
                  vx: pk(4, -4, 0, 0), vy: pk(0, 0, 0, 0),
                  evx: pk(-4, 4, 0, 0), evy: pk(0, 0, 0, 0), emask: 4'b0011, ncoll: 4'd1};
        vt[1] = '{px: pk(0, 10, 400, -400), py: pk(0, 10, 400, -400),
                  vx: pk(3, 0, 0, 0), vy: pk(3, 0, 0, 0),
                  evx: pk(0, 3, 0, 0), evy: pk(0, 3, 0, 0), emask: 4'b0011, ncoll: 4'd1};
        vt[2] = '{px: pk(0, 20, 400, -400), py: pk(0, 15, 400, -400),
                  vx: pk(5, 0, 0, 0), vy: pk(0, 0, 0, 0),
                  evx: pk(2, 3, 0, 0), evy: pk(-2, 2, 0, 0), emask: 4'b0011, ncoll: 4'd1};
        vt[3] = '{px: pk(0, 20, 400, -400), py: pk(0, 0, 400, -400),
                  vx: pk(4, 8, -9, 5), vy: pk(1, 2, 3, -6),
                  evx: pk(4, 8, -9, 5), evy: pk(1, 2, 3, -6), emask: 4'b0000, ncoll: 4'd0};
        vt[4] = '{px: pk(0, 32, 400, -400), py: pk(0, 0, 400, -400),
                  vx: pk(4, -4, -9, 5), vy: pk(1, 2, 3, -6),
                  evx: pk(4, -4, -9, 5), evy: pk(1, 2, 3, -6), emask: 4'b0000, ncoll: 4'd0};
        vt[5] = '{px: pk(0, 0, 400, -400), py: pk(0, 0, 400, -400),
                  vx: pk(4, -4, -9, 5), vy: pk(1, 2, 3, -6),
                  evx: pk(4, -4, -9, 5), evy: pk(1, 2, 3, -6), emask: 4'b0000, ncoll: 4'd0};
        vt[6] = '{px: pk(0, 20, 40, -400), py: pk(0, 0, 0, -400),
                  vx: pk(4, 0, 0, 0), vy: pk(0, 0, 0, 0),
                  evx: pk(0, 0, 4, 0), evy: pk(0, 0, 0, 0), emask: 4'b0111, ncoll: 4'd2};

        reset = 1'b1;
        start = 1'b0;
        pos_x_in = '0;
        pos_y_in = '0;
        vel_x_in = '0;
        vel_y_in = '0;
        repeat (3) @(negedge clk);
        chk("reset vx", 64'(vel_x_out), 64'd0);
        chk("reset vy", 64'(vel_y_out), 64'd0);
        chk("reset mask", 64'(collision_mask), 64'd0);
        chk("reset busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < NVEC; t++) begin
            apply_vec(t);
            run_pass(1'b0);
            chk($sformatf("vec%0d vx", t), 64'(snap_vx), 64'(vt[t].evx));
            chk($sformatf("vec%0d vy", t), 64'(snap_vy), 64'(vt[t].evy));
            chk($sformatf("vec%0d mask", t), 64'(snap_m), 64'(vt[t].emask));
            chk($sformatf("vec%0d latency", t), 64'(lat), 64'(exp_lat(int'(vt[t].ncoll))));
            chk($sformatf("vec%0d done_count", t), 64'(ndone), 64'd1);
        end

        // A start while busy must be dropped, not queued.
        apply_vec(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 3;
        lat   = 0;
        ndone = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (lat == 0) lat = cyc;
            end
        end
        chk("busy_start done_count", 64'(ndone), 64'd1);
        chk("busy_start latency", 64'(lat), 64'(exp_lat(1)));
        chk("busy_start busy_after", {63'd0, busy}, 64'd0);

        // Reset in the middle of the first X divide aborts the pass.
        apply_vec(6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort vx", 64'(vel_x_out), 64'd0);
        chk("abort vy", 64'(vel_y_out), 64'd0);
        chk("abort mask", 64'(collision_mask), 64'd0);
        chk("abort busy_done", {62'd0, busy, done}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no_done", 64'(ndone), 64'd0);
        run_pass(1'b0);
        chk("post_abort vx", 64'(snap_vx), 64'(vt[6].evx));
        chk("post_abort vy", 64'(snap_vy), 64'(vt[6].evy));
        chk("post_abort mask", 64'(snap_m), 64'(vt[6].emask));
        chk("post_abort latency", 64'(lat), 64'(exp_lat(2)));

        // Randomized clusters; every fourth pass uses full-range velocities to reach saturation.
        for (int r = 0; r < 40; r++) begin
            int px[NB], py[NB], vx[NB], vy[NB];
            for (int k = 0; k < NB; k++) begin
                px[k] = int'($urandom_range(60));
                py[k] = int'($urandom_range(60));
                if (r % 4 == 0) begin
                    vx[k] = int'($urandom_range(2047)) - 1024;
                    vy[k] = int'($urandom_range(2047)) - 1024;
                end else begin
                    vx[k] = int'($urandom_range(40)) - 20;
                    vy[k] = int'($urandom_range(40)) - 20;
                end
            end
            pos_x_in = pk(px[0], px[1], px[2], px[3]);
            pos_y_in = pk(py[0], py[1], py[2], py[3]);
            vel_x_in = pk(vx[0], vx[1], vx[2], vx[3]);
            vel_y_in = pk(vy[0], vy[1], vy[2], vy[3]);
            ref_model();
            for (int k = 0; k < NB; k++) begin
                evx[k*VW +: VW] = mv[k].x[VW-1:0];
                evy[k*VW +: VW] = mv[k].y[VW-1:0];
            end
            run_pass(r[0]);
            chk($sformatf("rnd%0d vx", r), 64'(snap_vx), 64'(evx));
            chk($sformatf("rnd%0d vy", r), 64'(snap_vy), 64'(evy));
            chk($sformatf("rnd%0d mask", r), 64'(snap_m), 64'(m_mask));
            chk($sformatf("rnd%0d latency", r), 64'(lat), 64'(exp_lat(m_coll)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
